// File: rtl/my_serdes_rx_pkg.sv
// Shared constants and types for the SERDES receive deframer.
package serdes_pkg;

  localparam logic [15:0] K_COMMA = 16'hBCBC;
  localparam logic [15:0] K_SYNC  = 16'h3CBC;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    ERROR    = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    DATA,
    COMMA,
    SYNC,
    BAD
  } word_class_t;

  // k is {high-byte flag, low-byte flag}; mixed K-flags are always BAD.
  function automatic word_class_t classify(input logic [15:0] w, input logic [1:0] k);
    if (k == 2'b00)
      return DATA;
    if (k == 2'b11 && w == K_COMMA)
      return COMMA;
    if (k == 2'b11 && w == K_SYNC)
      return SYNC;
    return BAD;
  endfunction

endpackage

// File: rtl/my_serdes_rx_fifo.sv
// First-word-fall-through sample FIFO with level, full and empty status.
module serdes_rx_fifo #(
  parameter int FIFOSIZE   = 1024,
  parameter int CNTR_WIDTH = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNTR_WIDTH:0]   level
);

  localparam logic [CNTR_WIDTH:0] FULL_LVL = (CNTR_WIDTH+1)'(FIFOSIZE);

  logic [WIDTH-1:0]      mem [FIFOSIZE];
  logic [CNTR_WIDTH-1:0] wr_ptr_q;
  logic [CNTR_WIDTH-1:0] rd_ptr_q;
  logic [CNTR_WIDTH:0]   count_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);
  assign level = count_q;

  // Full is judged on the pre-read level, so a write into a full FIFO is
  // dropped even when a read frees a slot on the same edge.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr_q <= wr_ptr_q + CNTR_WIDTH'(1);
      if (rd_ok)
        rd_ptr_q <= rd_ptr_q + CNTR_WIDTH'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (CNTR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (CNTR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/my_serdes_rx.sv
// SERDES receive deframer: SYNC lock, COMMA skip, word pairing into a sample FIFO.
// Optional error counter output rx_err_cnt enabled by SERDES_RX_ERR_CNT_EN.
module my_serdes_rx #(
  parameter int FIFOSIZE   = 1024,
  parameter int CNTR_WIDTH = 10
) (
  input  logic                  dsp_clk,
  input  logic                  dsp_rst,
  input  logic [15:0]           ser_r,
  input  logic                  ser_rklsb,
  input  logic                  ser_rkmsb,
  output logic [31:0]           rx_dat_o,
  output logic                  rx_rdy,
  input  logic                  rx_en,
  output logic                  link_up,
  output logic                  rx_error,
  output logic                  rx_overrun,
  output logic [CNTR_WIDTH:0]   fifo_level,
  output logic [7:0]            debug
`ifdef SERDES_RX_ERR_CNT_EN
  ,
  output logic [15:0]           rx_err_cnt
`endif
);

  import serdes_pkg::*;

  logic [15:0]  word_q;
  logic [1:0]   k_q;
  word_class_t  wclass;

  rx_state_t    state_q, state_d;
  logic         parity_q, parity_d;
  logic [15:0]  held_q, held_d;
  logic         wr_q, wr_d;
  logic [31:0]  wr_data_q, wr_data_d;

  logic         fifo_full;
  logic         fifo_empty;

  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      word_q <= '0;
      k_q    <= '0;
    end else begin
      word_q <= ser_r;
      k_q    <= {ser_rkmsb, ser_rklsb};
    end
  end

  assign wclass = classify(word_q, k_q);

  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      state_q   <= UNLOCKED;
      parity_q  <= 1'b0;
      held_q    <= '0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      held_q    <= held_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Completed samples pass through one register stage before the FIFO write,
  // giving two edges from the second word's capture to rx_rdy.
  always_comb begin
    state_d   = state_q;
    parity_d  = parity_q;
    held_d    = held_q;
    wr_d      = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      UNLOCKED: begin
        if (wclass == SYNC) begin
          state_d  = LOCKED;
          parity_d = 1'b0;
        end
      end
      LOCKED: begin
        case (wclass)
          DATA: begin
            if (!parity_q) begin
              held_d   = word_q;
              parity_d = 1'b1;
            end else begin
              wr_d      = 1'b1;
              wr_data_d = {held_q, word_q};
              parity_d  = 1'b0;
            end
          end
          COMMA, SYNC: begin
            if (parity_q) begin
              state_d  = ERROR;
              parity_d = 1'b0;
            end
          end
          default: begin
            state_d  = ERROR;
            parity_d = 1'b0;
          end
        endcase
      end
      ERROR: begin
        state_d  = UNLOCKED;
        parity_d = 1'b0;
      end
      default: begin
        state_d  = UNLOCKED;
        parity_d = 1'b0;
      end
    endcase
  end

  serdes_rx_fifo #(
    .FIFOSIZE   (FIFOSIZE),
    .CNTR_WIDTH (CNTR_WIDTH),
    .WIDTH      (32)
  ) u_fifo (
    .clk     (dsp_clk),
    .rst     (dsp_rst),
    .wr_en   (wr_q),
    .wr_data (wr_data_q),
    .rd_en   (rx_en),
    .rd_data (rx_dat_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign rx_rdy     = ~fifo_empty;
  assign link_up    = (state_q == LOCKED);
  assign rx_error   = (state_q == ERROR);
  assign rx_overrun = wr_q & fifo_full;

  assign debug = {link_up, rx_error, rx_overrun, rx_rdy, rx_en, parity_q, 2'(state_q)};

`ifdef SERDES_RX_ERR_CNT_EN
  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst)
      rx_err_cnt <= '0;
    else if ((rx_error | rx_overrun) && rx_err_cnt != '1)
      rx_err_cnt <= rx_err_cnt + 16'd1;
  end
`endif

endmodule
